// File: rtl/deparser_pkg.sv
// Shared definitions for the deparser back end: header-slice tag layout,
// merger FSM states and byte/bit helpers.
package deparser_pkg;

  localparam int DATA_W         = 512;
  localparam int TAG_WIDTH      = 10;
  localparam int TAG_OFFSET_LSB = 0;
  localparam int TAG_OFFSET_W   = 6;
  localparam int TAG_START_BIT  = 6;
  localparam int TAG_TAIL_BIT   = 7;
  localparam int TAG_SHIFT_BIT  = 8;
  localparam int TAG_VALID_BIT  = 9;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEAD    = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_FLUSH   = 2'd3
  } state_e;

  function automatic logic [9:0] bytes_to_bits(input logic [6:0] nbytes);
    return {nbytes, 3'b000};
  endfunction

endpackage

// File: rtl/deparser_hfifo.sv
// Header-slice FIFO. A push while full is accepted only if a pop frees a slot
// in the same cycle; the head entry is presented combinationally.
module deparser_hfifo #(
  parameter int W     = 520,
  parameter int DEPTH = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q;
  logic [AW:0]  rd_ptr_q;
  logic         do_push;
  logic         do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are meaningful, and a reset here would cost a mux per bit.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/deparser_pkt_merger.sv
// Merges buffered header slices and the payload stream into one byte-packed
// packet stream, realigning payload behind the last partial header slice.
module deparser_pkt_merger #(
  parameter int DATA_W      = 512,
  parameter int HFIFO_DEPTH = 16,
  parameter int CNT_W       = 16
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst,
  input  logic [DATA_W+deparser_pkg::TAG_WIDTH-1:0] i_head,
  input  logic                                   i_pl_valid,
  output logic                                   o_pl_ready,
  input  logic [DATA_W-1:0]                      i_pl_data,
  input  logic                                   i_pl_last,
  input  logic [6:0]                             i_pl_bytes,
  output logic                                   o_pkt_valid,
  input  logic                                   i_pkt_ready,
  output logic [DATA_W-1:0]                      o_pkt_data,
  output logic                                   o_pkt_last,
  output logic [6:0]                             o_pkt_bytes,
  output logic                                   o_drop_pulse,
  output logic [CNT_W-1:0]                       o_drop_cnt
);

  import deparser_pkg::*;

  localparam int         SLW      = DATA_W + 2 + TAG_OFFSET_W;
  localparam logic [6:0] FULL_BEAT = 7'(DATA_W / 8);

  function automatic logic [DATA_W-1:0] lane_mask(input logic [6:0] nbytes);
    return ~({DATA_W{1'b1}} >> bytes_to_bits(nbytes));
  endfunction

  // Header FIFO
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [SLW-1:0]    fifo_wdata;
  logic [SLW-1:0]    fifo_head;
  logic [DATA_W-1:0] h_data;
  logic              h_tail;
  logic              h_start;
  logic [5:0]        h_off;
  logic              unused_shift;

  assign fifo_push    = i_head[TAG_VALID_BIT];
  assign unused_shift = i_head[TAG_SHIFT_BIT];
  assign fifo_wdata   = {i_head[TAG_WIDTH +: DATA_W], i_head[TAG_TAIL_BIT],
                         i_head[TAG_START_BIT], i_head[TAG_OFFSET_LSB +: TAG_OFFSET_W]};
  assign {h_data, h_tail, h_start, h_off} = fifo_head;

  deparser_hfifo #(
    .W     (SLW),
    .DEPTH (HFIFO_DEPTH)
  ) u_hfifo (
    .clk_i       (i_clk),
    .rst_i       (i_rst),
    .push_i      (fifo_push),
    .push_data_i (fifo_wdata),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  state_e            state_q, state_d;
  logic              pkt_valid_q, pkt_valid_d;
  logic [DATA_W-1:0] pkt_data_q, pkt_data_d;
  logic              pkt_last_q, pkt_last_d;
  logic [6:0]        pkt_bytes_q, pkt_bytes_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic [5:0]        res_bytes_q, res_bytes_d;
  logic              drop_pulse_q;
  logic [CNT_W-1:0]  drop_cnt_q;
  logic              stray_drop;
  logic              drop_evt;

  logic                adv;
  logic                pl_fire;
  logic [DATA_W-1:0]   pl_masked;
  logic [2*DATA_W-1:0] merged;
  logic [7:0]          sum;

  assign adv        = ~pkt_valid_q | i_pkt_ready;
  assign o_pl_ready = (state_q == ST_PAYLOAD) & adv;
  assign pl_fire    = o_pl_ready & i_pl_valid;
  assign pl_masked  = i_pl_data & lane_mask(i_pl_bytes);
  assign sum        = {2'b00, res_bytes_q} + {1'b0, i_pl_bytes};

  // Residual occupies the top res_bytes lanes; payload slides in right behind
  // it, and whatever spills past one beat lands left-aligned in the low half.
  assign merged = {res_data_q, {DATA_W{1'b0}}} |
                  ({pl_masked, {DATA_W{1'b0}}} >> bytes_to_bits({1'b0, res_bytes_q}));

  // NOTE: every combinational output gets a default before the case so no
  // path leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d     = state_q;
    pkt_valid_d = pkt_valid_q & ~adv;
    pkt_data_d  = pkt_data_q;
    pkt_last_d  = pkt_last_q;
    pkt_bytes_d = pkt_bytes_q;
    res_data_d  = res_data_q;
    res_bytes_d = res_bytes_q;
    fifo_pop    = 1'b0;
    stray_drop  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          if (h_start) begin
            state_d = ST_HEAD;
          end else begin
            fifo_pop   = 1'b1;
            stray_drop = 1'b1;
          end
        end
      end

      ST_HEAD: begin
        if (adv && !fifo_empty) begin
          fifo_pop = 1'b1;
          if (!h_tail || h_off == 6'd63) begin
            pkt_valid_d = 1'b1;
            pkt_data_d  = h_data;
            pkt_last_d  = 1'b0;
            pkt_bytes_d = FULL_BEAT;
          end
          if (h_tail) begin
            state_d = ST_PAYLOAD;
            if (h_off == 6'd63) begin
              res_data_d  = '0;
              res_bytes_d = '0;
            end else begin
              res_data_d  = h_data & lane_mask({1'b0, h_off} + 7'd1);
              res_bytes_d = h_off + 6'd1;
            end
          end
        end
      end

      ST_PAYLOAD: begin
        if (pl_fire) begin
          pkt_valid_d = 1'b1;
          pkt_data_d  = merged[2*DATA_W-1 -: DATA_W];
          if (!i_pl_last) begin
            pkt_last_d  = 1'b0;
            pkt_bytes_d = FULL_BEAT;
            res_data_d  = merged[DATA_W-1:0];
          end else if (sum <= {1'b0, FULL_BEAT}) begin
            pkt_last_d  = 1'b1;
            pkt_bytes_d = 7'(sum);
            res_data_d  = '0;
            res_bytes_d = '0;
            state_d     = ST_IDLE;
          end else begin
            pkt_last_d  = 1'b0;
            pkt_bytes_d = FULL_BEAT;
            res_data_d  = merged[DATA_W-1:0];
            res_bytes_d = 6'(sum - {1'b0, FULL_BEAT});
            state_d     = ST_FLUSH;
          end
        end
      end

      ST_FLUSH: begin
        if (adv) begin
          pkt_valid_d = 1'b1;
          pkt_data_d  = res_data_q;
          pkt_last_d  = 1'b1;
          pkt_bytes_d = {1'b0, res_bytes_q};
          res_data_d  = '0;
          res_bytes_d = '0;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign drop_evt = (fifo_push & fifo_full & ~fifo_pop) | stray_drop;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      pkt_valid_q  <= 1'b0;
      pkt_data_q   <= '0;
      pkt_last_q   <= 1'b0;
      pkt_bytes_q  <= '0;
      res_data_q   <= '0;
      res_bytes_q  <= '0;
      drop_pulse_q <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      pkt_valid_q  <= pkt_valid_d;
      pkt_data_q   <= pkt_data_d;
      pkt_last_q   <= pkt_last_d;
      pkt_bytes_q  <= pkt_bytes_d;
      res_data_q   <= res_data_d;
      res_bytes_q  <= res_bytes_d;
      drop_pulse_q <= drop_evt;
      if (drop_evt && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  assign o_pkt_valid  = pkt_valid_q;
  assign o_pkt_data   = pkt_data_q;
  assign o_pkt_last   = pkt_last_q;
  assign o_pkt_bytes  = pkt_bytes_q;
  assign o_drop_pulse = drop_pulse_q;
  assign o_drop_cnt   = drop_cnt_q;

endmodule
